// File: rtl/pb_event_pkg.sv
// Purpose : shared types and default timing constants for the push-button event decoder.
// Contents: pb_state_t (decoder FSM states), default LONG/DCLICK/CNT widths, pb_max helper.
// Used by : pb_event_decoder (import pb_event_pkg::*).
package pb_event_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    GAP    = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } pb_state_t;

  // 0.5 s long press and 0.25 s double-click window at 100 MHz.
  localparam int unsigned PB_LONG_CYC_DEF   = 50_000_000;
  localparam int unsigned PB_DCLICK_CYC_DEF = 25_000_000;
  localparam int unsigned PB_CNT_W_DEF      = 8;

  function automatic int unsigned pb_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pb_edge_detect.sv
// Purpose : edge detector on the debounced button level; rise/fall are combinational on d.
// Latency : rise/fall valid in the same cycle d changes; q is d delayed by one clock.
// Ports   : clk, rst (async active-low), d in; rise, fall, q (previous level) out.
module pb_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall,
  output logic q
);

  logic prev_q;

  // Resetting to 1 means a button held through reset is not seen as a press;
  // it has to be released and pressed again.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= d;
    end
  end

  assign rise = d & ~prev_q;
  assign fall = ~d & prev_q;
  assign q    = prev_q;

endmodule

// File: rtl/pb_event_decoder.sv
// Purpose : turns the debounced button level into press/release/single/double/long one-cycle pulses.
// Latency : every output is registered, 1 clk from a DEBOUNCED change to its pulse.
// Backpressure: none; pulses are fire-and-forget, downstream must sample every cycle.
// Ports   : clk, rst (async active-low), DEBOUNCED in; press_pulse, release_pulse, single_click,
//           double_click, long_press, held, press_count[CNT_W] out.
// Option  : define PB_EVT_COUNT_EN to build the saturating press counter; otherwise press_count is 0.
module pb_event_decoder
  import pb_event_pkg::*;
#(
  parameter int unsigned LONG_CYC   = PB_LONG_CYC_DEF,
  parameter int unsigned DCLICK_CYC = PB_DCLICK_CYC_DEF,
  parameter int unsigned CNT_W      = PB_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             DEBOUNCED,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             single_click,
  output logic             double_click,
  output logic             long_press,
  output logic             held,
  output logic [CNT_W-1:0] press_count
);

  localparam int unsigned TMR_W = $clog2(pb_max(LONG_CYC, DCLICK_CYC)) + 1;
  localparam logic [TMR_W-1:0] LONG_LAST   = TMR_W'(LONG_CYC - 1);
  localparam logic [TMR_W-1:0] DCLICK_LAST = TMR_W'(DCLICK_CYC - 1);

  logic rise, fall, prev_lvl;

  pb_edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (DEBOUNCED),
    .rise (rise),
    .fall (fall),
    .q    (prev_lvl)
  );

  pb_state_t        state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             long_d, single_d, double_d;

  always_comb begin
    state_d  = state_q;
    long_d   = 1'b0;
    single_d = 1'b0;
    double_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) state_d = PRESS1;
      end
      PRESS1: begin
        // A release in the expiry cycle is a short press, not a long one.
        if (fall) begin
          state_d = GAP;
        end else if (timer_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = LONG;
        end
      end
      GAP: begin
        // A second press in the expiry cycle still counts as a double click.
        if (rise) begin
          double_d = 1'b1;
          state_d  = PRESS2;
        end else if (timer_q == DCLICK_LAST) begin
          single_d = 1'b1;
          state_d  = IDLE;
        end
      end
      PRESS2, LONG: begin
        if (fall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Timer measures time spent in the current state; it saturates so that long
  // dwell in IDLE/PRESS2/LONG cannot wrap back onto an expiry value.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q != '1) begin
      timer_d = timer_q + TMR_W'(1);
    end
  end

  logic press_q, release_q, single_q, double_q, long_q, armed_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      single_q  <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      press_q   <= rise;
      release_q <= fall;
      single_q  <= single_d;
      double_q  <= double_d;
      long_q    <= long_d;
      armed_q   <= 1'b1;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign single_click  = single_q;
  assign double_click  = double_q;
  assign long_press    = long_q;
  // prev_lvl already holds DEBOUNCED delayed one clock but resets high;
  // armed_q masks it to 0 until the first clock after reset.
  assign held          = prev_lvl & armed_q;

`ifdef PB_EVT_COUNT_EN
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (rise && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign press_count = count_q;
`else
  assign press_count = '0;
`endif

endmodule

// File: tb/tb_pb_event_decoder.sv
module tb_pb_event_decoder;

  localparam int LONG  = 20;
  localparam int DCLK  = 10;
  localparam int CW    = 2;
`ifdef PB_EVT_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic deb = 1'b0;
  logic press_pulse, release_pulse, single_click, double_click, long_press, held;
  logic [CW-1:0] press_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pb_event_decoder #(
    .LONG_CYC   (LONG),
    .DCLICK_CYC (DCLK),
    .CNT_W      (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .DEBOUNCED     (deb),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .single_click  (single_click),
    .double_click  (double_click),
    .long_press    (long_press),
    .held          (held),
    .press_count   (press_count)
  );

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (timestamp based) ----------------
  typedef enum {M_IDLE, M_FIRST, M_WAIT, M_SECOND, M_HELD} mode_t;
  mode_t mode = M_IDLE;
  int    cyc = 0;       // clock edges seen out of reset
  int    t_mark = 0;    // edge index where the current press / gap began
  bit    m_prev = 1'b1;
  bit    e_press = 0, e_release = 0, e_single = 0, e_double = 0, e_long = 0, e_held = 0;
  int    e_count = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      e_press = 0; e_release = 0; e_single = 0; e_double = 0; e_long = 0;
      if (!rst) begin
        m_prev  = 1'b1;
        mode    = M_IDLE;
        e_held  = 0;
        e_count = 0;
      end else begin
        bit r, f;
        cyc++;
        r = deb & ~m_prev;
        f = ~deb & m_prev;
        m_prev    = deb;
        e_press   = r;
        e_release = f;
        e_held    = deb;
        case (mode)
          M_IDLE:  if (r) begin mode = M_FIRST; t_mark = cyc; end
          M_FIRST: if (f) begin mode = M_WAIT; t_mark = cyc; end
                   else if (cyc - t_mark == LONG) begin e_long = 1; mode = M_HELD; end
          M_WAIT:  if (r) begin e_double = 1; mode = M_SECOND; end
                   else if (cyc - t_mark == DCLK) begin e_single = 1; mode = M_IDLE; end
          default: if (f) mode = M_IDLE;
        endcase
        if (r && COUNT_EN && e_count < (1 << CW) - 1) e_count++;
      end
    end
  end

  // ---------------- compare + event monitor ----------------
  bit chk_en = 0;
  int n_press, n_rel, n_single, n_double, n_long;
  int c_press, c_rel, c_single, c_double, c_long;

  task automatic clear_mon();
    n_press = 0; n_rel = 0; n_single = 0; n_double = 0; n_long = 0;
  endtask

  initial begin
    clear_mon();
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("press_pulse",   press_pulse,   e_press);
        check("release_pulse", release_pulse, e_release);
        check("single_click",  single_click,  e_single);
        check("double_click",  double_click,  e_double);
        check("long_press",    long_press,    e_long);
        check("held",          held,          e_held);
        check("press_count",   press_count,   e_count);
      end
      if (press_pulse)   begin n_press++;  c_press  = cyc; end
      if (release_pulse) begin n_rel++;    c_rel    = cyc; end
      if (single_click)  begin n_single++; c_single = cyc; end
      if (double_click)  begin n_double++; c_double = cyc; end
      if (long_press)    begin n_long++;   c_long   = cyc; end
    end
  end

  task automatic drive(input bit v, input int n);
    deb = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int exp_cnt[5];
  int t0;

  initial begin
    if (COUNT_EN) exp_cnt = '{1, 2, 3, 3, 3};
    else          exp_cnt = '{0, 0, 0, 0, 0};

    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1;
    check("rst_press",   press_pulse, 0);
    check("rst_single",  single_click, 0);
    check("rst_long",    long_press, 0);
    check("rst_held",    held, 0);
    check("rst_count",   press_count, 0);
    rst = 1'b1;
    drive(0, 3);

    // 1: short press, then idle -> single click 10 edges after the release
    clear_mon();
    t0 = cyc;
    drive(1, 5);
    drive(0, 12);
    check("s1_press_n",     n_press, 1);
    check("s1_press_lat",   c_press - t0, 1);
    check("s1_release_n",   n_rel, 1);
    check("s1_single_n",    n_single, 1);
    check("s1_single_dly",  c_single - c_rel, 10);
    check("s1_other_n",     n_double + n_long, 0);

    // 2: double click
    clear_mon();
    drive(1, 5); drive(0, 4); drive(1, 5); drive(0, 12);
    check("s2_press_n",   n_press, 2);
    check("s2_double_n",  n_double, 1);
    check("s2_double_at", c_double - c_press, 0);
    check("s2_single_n",  n_single, 0);

    // 3: long press
    clear_mon();
    drive(1, 25); drive(0, 12);
    check("s3_long_n",    n_long, 1);
    check("s3_long_dly",  c_long - c_press, 20);
    check("s3_release_n", n_rel, 1);
    check("s3_click_n",   n_single + n_double, 0);

    // 4a: release exactly at long-press expiry -> short press
    clear_mon();
    drive(1, 20); drive(0, 12);
    check("s4a_long_n",   n_long, 0);
    check("s4a_single_n", n_single, 1);

    // 4b: second press exactly at gap expiry -> double click
    clear_mon();
    drive(1, 3); drive(0, 10); drive(1, 3);
    check("s4b_double_n",   n_double, 1);
    check("s4b_double_gap", c_double - c_rel, 10);
    drive(0, 12);
    check("s4b_single_n",   n_single, 0);

    // 5: reset during the gap with the button held through reset
    drive(1, 3); drive(0, 3);
    rst = 1'b0; deb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("s5_rst_release", release_pulse, 0);
    check("s5_rst_double",  double_click, 0);
    check("s5_rst_held",    held, 0);
    rst = 1'b1;
    clear_mon();
    drive(1, 5);
    check("s5_no_press",  n_press, 0);
    check("s5_held",      held, 1);
    drive(0, 3); drive(1, 3); drive(0, 12);
    check("s5_press_n",   n_press, 1);
    check("s5_single_n",  n_single + n_double, 1);

    // 6: press counter
    rst = 1'b0; deb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 2);
    for (int i = 0; i < 5; i++) begin
      drive(1, 2);
      check($sformatf("s6_count_%0d", i), press_count, exp_cnt[i]);
      drive(0, 12);
    end

    // random traffic against the model, with occasional resets
    for (int s = 0; s < 400; s++) begin
      int dur;
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b0;
        deb = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        rst = 1'b1;
      end
      case ($urandom_range(0, 3))
        0:       dur = $urandom_range(1, 4);
        1:       dur = $urandom_range(5, 12);
        2:       dur = $urandom_range(8, 11);
        default: dur = $urandom_range(15, 30);
      endcase
      drive(~deb, dur);
    end
    drive(0, 15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
